// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM arbiter: FSM encoding, bus widths, pending-read entry.
package sdram_arb_pkg;

  localparam int BURST_W = 8;
  localparam int DATA_W  = 64;
  localparam int BE_W    = 8;
  // Wide enough for the largest supported requester count (4).
  localparam int ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    READ_CMD    = 2'd1,
    WRITE_BURST = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [BURST_W-1:0] beats;
  } pend_t;

  // A burstcount of zero is treated as a single beat.
  function automatic logic [BURST_W-1:0] norm_burst(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? BURST_W'(1) : bc;
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester-side and SDRAM-side Avalon-MM bundles for the SDRAM arbiter.
interface sdram_req_if
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 29
);
  logic [NUM_REQ*ADDR_W-1:0]  req_address;
  logic [NUM_REQ*BURST_W-1:0] req_burstcount;
  logic [NUM_REQ-1:0]         req_read;
  logic [NUM_REQ-1:0]         req_write;
  logic [NUM_REQ*DATA_W-1:0]  req_writedata;
  logic [NUM_REQ*BE_W-1:0]    req_byteenable;
  logic [NUM_REQ-1:0]         req_waitrequest;
  logic [DATA_W-1:0]          req_readdata;
  logic [NUM_REQ-1:0]         req_readdatavalid;

  modport master (
    output req_address, req_burstcount, req_read, req_write, req_writedata, req_byteenable,
    input  req_waitrequest, req_readdata, req_readdatavalid
  );

  modport slave (
    input  req_address, req_burstcount, req_read, req_write, req_writedata, req_byteenable,
    output req_waitrequest, req_readdata, req_readdatavalid
  );
endinterface

interface sdram_mem_if
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = 29
);
  logic [ADDR_W-1:0]  address;
  logic [BURST_W-1:0] burstcount;
  logic               read;
  logic               write;
  logic [DATA_W-1:0]  writedata;
  logic [BE_W-1:0]    byteenable;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  modport master (
    output address, burstcount, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_arb_id_fifo.sv
// FIFO of outstanding read commands {requester id, beats}; push and pop may coincide,
// including a push into a full FIFO that is popping in the same cycle.
module sdram_arb_id_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset_n,
  input  logic  i_push,
  input  pend_t i_push_dat,
  input  logic  i_pop,
  output pend_t o_head,
  output logic  o_full,
  output logic  o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pend_t          r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_wr;
  logic           w_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin sharing of one Avalon-MM SDRAM master among NUM_REQ clients, read data routed
// back by an ID FIFO. Define SDRAM_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins priority.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int MAX_PENDING = 4,
  parameter int ADDR_W      = 29
) (
  input  logic        clock,
  input  logic        reset_n,
  sdram_req_if.slave  req,
  sdram_mem_if.master mem,
  output logic        o_protocol_err
);

  localparam int GW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_READ  = READ_CMD;
  localparam logic [1:0] S_WRITE = WRITE_BURST;

  logic [1:0]         r_state;
  logic [GW-1:0]      r_grant;
  logic [BURST_W-1:0] r_wr_left;
  logic [BURST_W-1:0] r_rd_cnt;
  logic               r_protocol_err;
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
`else
  logic [GW-1:0]      r_last;
`endif

  logic [NUM_REQ-1:0] w_elig;
  logic               w_found;
  logic [GW-1:0]      w_pick;
  logic               w_pick_wr;
  logic [BURST_W-1:0] w_pick_bc;
  logic               w_act;
  logic [ADDR_W-1:0]  w_addr;
  logic [BURST_W-1:0] w_bc;
  logic [DATA_W-1:0]  w_wd;
  logic [BE_W-1:0]    w_be;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  pend_t              w_push_dat;
  pend_t              w_head;

  assign w_elig = req.req_write | (req.req_read & {NUM_REQ{!w_full}});

  // Lowest eligible index overall, then (round-robin) overridden by the lowest one above last grant.
  always_comb begin
    w_found   = 1'b0;
    w_pick    = '0;
    w_pick_wr = 1'b0;
    w_pick_bc = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_found   = 1'b1;
        w_pick    = GW'(i);
        w_pick_wr = req.req_write[i];
        w_pick_bc = req.req_burstcount[i*BURST_W +: BURST_W];
      end
    end
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
`else
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_elig[i] && (i > int'(r_last))) begin
        w_pick    = GW'(i);
        w_pick_wr = req.req_write[i];
        w_pick_bc = req.req_burstcount[i*BURST_W +: BURST_W];
      end
    end
`endif
  end

  always_comb begin
    w_addr = '0;
    w_bc   = '0;
    w_wd   = '0;
    w_be   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == r_grant) begin
        w_addr = req.req_address[i*ADDR_W +: ADDR_W];
        w_bc   = norm_burst(req.req_burstcount[i*BURST_W +: BURST_W]);
        w_wd   = req.req_writedata[i*DATA_W +: DATA_W];
        w_be   = req.req_byteenable[i*BE_W +: BE_W];
      end
    end
  end

  assign w_act    = (r_state != S_IDLE);
  assign w_gnt_oh = NUM_REQ'(1) << r_grant;

  assign mem.address    = w_act ? w_addr : '0;
  assign mem.burstcount = w_act ? w_bc : '0;
  assign mem.writedata  = w_act ? w_wd : '0;
  assign mem.byteenable = w_act ? w_be : '0;
  assign mem.read       = (r_state == S_READ);
  assign mem.write      = (r_state == S_WRITE);

  assign req.req_waitrequest = w_act ? (~w_gnt_oh | {NUM_REQ{mem.waitrequest}}) : '1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_wr_left <= '0;
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
`else
      r_last    <= GW'(NUM_REQ - 1);
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
`else
            r_last  <= w_pick;
`endif
            if (w_pick_wr) begin
              r_state   <= S_WRITE;
              r_wr_left <= norm_burst(w_pick_bc);
            end else begin
              r_state   <= S_READ;
            end
          end
        end
        S_READ: begin
          if (!mem.waitrequest) r_state <= S_IDLE;
        end
        S_WRITE: begin
          if (!mem.waitrequest) begin
            r_wr_left <= r_wr_left - 1'b1;
            if (r_wr_left == BURST_W'(1)) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read return path: independent of the command FSM.
  assign w_push     = (r_state == S_READ) && !mem.waitrequest;
  assign w_push_dat = '{id: ID_W'(r_grant), beats: w_bc};
  assign w_pop      = mem.readdatavalid && !w_empty &&
                      (r_rd_cnt == (w_head.beats - BURST_W'(1)));

  assign req.req_readdata      = mem.readdata;
  assign req.req_readdatavalid = (mem.readdatavalid && !w_empty) ?
                                 (NUM_REQ'(1) << w_head.id) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_cnt       <= '0;
      r_protocol_err <= 1'b0;
    end else if (mem.readdatavalid) begin
      if (w_empty)    r_protocol_err <= 1'b1;
      else if (w_pop) r_rd_cnt       <= '0;
      else            r_rd_cnt       <= r_rd_cnt + 1'b1;
    end
  end

  assign o_protocol_err = r_protocol_err;

  sdram_arb_id_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_id_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares one Avalon-MM SDRAM master port (29-bit word address, 64-bit data, 8-bit burstcount) between NUM_REQ requesters, e.g. scanout reads and rasterizer writes.
- Round-robin arbitration per command.
- Tracks outstanding reads in an ID FIFO and routes returning readdata/readdatavalid to the requester that issued the read.
- Sits between the HPS F2H-SDRAM bridge and the Alice4 graphics clients.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- MAX_PENDING, 4: maximum outstanding read commands (power of 2).
- ADDR_W, 29: word address width.

Ports:
- clock  in  1  system clock
- reset_n  in  1  async active-low reset
- req_address  in  NUM_REQ*ADDR_W  per-requester address, packed, requester i at [i*ADDR_W +: ADDR_W]
- req_burstcount  in  NUM_REQ*8  per-requester burst length (1..255; 0 treated as 1)
- req_read  in  NUM_REQ  read request
- req_write  in  NUM_REQ  write request
- req_writedata  in  NUM_REQ*64  write data
- req_byteenable  in  NUM_REQ*8  byte enables
- req_waitrequest  out  NUM_REQ  per-requester waitrequest
- req_readdata  out  64  shared read data bus
- req_readdatavalid  out  NUM_REQ  one-hot data-valid
- address  out  ADDR_W  master address
- burstcount  out  8  master burstcount
- read  out  1  master read
- write  out  1  master write
- writedata  out  64  master write data
- byteenable  out  8  master byte enables
- waitrequest  in  1  master waitrequest
- readdata  in  64  master read data
- readdatavalid  in  1  master read data valid

Behaviour:
- Reset: state IDLE, grant none, last-granted = NUM_REQ-1, FIFO empty, beat counters 0. Outputs: read=0, write=0, req_waitrequest all 1, req_readdatavalid all 0, address/burstcount/writedata/byteenable 0.
- States:
  - IDLE
  - READ_CMD
  - WRITE_BURST
- IDLE:
  - Requester i is eligible if req_write[i], or if req_read[i] and FIFO not full.
  - Round-robin: pick the first eligible requester after last-granted.
  - If that requester asserts both read and write, write wins.
  - Register grant; go to READ_CMD or WRITE_BURST. Master command asserts the next cycle (1-cycle arbitration latency).
- While granted, master address/burstcount/writedata/byteenable mux combinationally from the granted requester. req_waitrequest[grant] = waitrequest; all others = 1.
- READ_CMD:
  - read=1.
  - On the cycle with !waitrequest: push {grant, burstcount} into the FIFO, drop read, go to IDLE.
- WRITE_BURST:
  - write=1; beat counter loads burstcount.
  - Each cycle with !waitrequest decrements the counter.
  - The requester must keep req_write asserted and supply the next beat's data.
  - After the final beat: write=0, go to IDLE.
- Read return, independent of state:
  - On readdatavalid, req_readdata = readdata (combinational) and req_readdatavalid[FIFO head id] = 1.
  - The head beat counter decrements; pop when it reaches 0.
- Boundaries:
  - readdatavalid with FIFO empty: ignored, and sticky protocol_err bit set (internal, visible in simulation).
  - Push and pop in the same cycle are both honoured; full+push-while-pop is allowed.
  - A requester deasserting its request mid-command is a protocol violation; the arbiter holds the command until accepted.
  - Requests during any non-IDLE state wait (req_waitrequest=1).
- Reset mid-burst aborts all state immediately. The SDRAM side must be reset together.

Optional Feature:
- SDRAM_ARB_FIXED_PRIORITY_EN
  - Defined: fixed priority, lowest index wins, last-granted unused. Intended for making scanout requester 0 never starve.
  - Undefined: round-robin as above.

Decomposition:
- Package sdram_arb_pkg holds:
  - state enum (IDLE/READ_CMD/WRITE_BURST)
  - BURST_W=8, DATA_W=64, BE_W=8
  - pending-entry struct {id, beats}
- One sub-module, sdram_arb_id_fifo:
  - synchronous FIFO of pending entries, depth MAX_PENDING
  - full/empty flags and head output
  - simultaneous push/pop supported

Test Plan:
- Single write from req1 addr 0x0700_0000, data 0xDEAD_BEEF_CAFE_BABE, waitrequest low -> write=1 exactly one cycle, address/data match, req_waitrequest[1] low that cycle.
- Write then read back by req0, readdatavalid 5 cycles later with 0xDEAD_BEEF_CAFE_BABE -> req_readdatavalid=2'b01 with matching data, req_readdatavalid[1] never high.
- req0 and req1 both request reads continuously -> grants alternate 0,1,0,1; each read returns to its issuer in order.
- Read burstcount 4 from req1 plus read burstcount 1 from req0 outstanding -> 4 valids to req1, then 1 to req0.
- MAX_PENDING=4 reads issued with no data returned -> fifth read stalls (req_waitrequest high) until first burst completes; writes still granted.
- Assert reset_n low mid write burst (beat 2 of 4) -> read/write 0 and req_waitrequest all 1 that cycle; after release, normal arbitration from IDLE.
